// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: command front-end for a downstream SR flip-flop.
// Raw set/clear requests are synchronised, debounced and turned into rising-edge
// events. A small IDLE/PULSE/LOCK machine then issues clean one-cycle s or r
// pulses, with a forced quiet interval after each one. Events that arrive while
// the machine is busy are parked in per-channel pending flags. Commands that q
// already satisfies are silently dropped, and s and r are never high together.
module sr_drive_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int LOCKOUT   = 2,
  parameter int PRIO      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  output logic s,
  output logic r,
  output logic busy,
  output logic err_both
);

  localparam int CW = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'((DB_CYCLES < 1) ? 0 : DB_CYCLES - 1);
  localparam int LW = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'((LOCKOUT > 0) ? LOCKOUT - 1 : 0);
  localparam bit SET_WINS = (PRIO != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    LOCK  = 2'd2
  } state_t;

  // Channel 0 carries set requests and channel 1 carries clear requests.
  logic [1:0]    req_raw;
  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [1:0]    stable;
  logic [1:0]    stable_d;
  logic [1:0]    events;
  logic [CW-1:0] db_cnt [2];

  state_t        state;
  state_t        state_n;
  logic          s_n;
  logic          r_n;
  logic [1:0]    pend;
  logic [1:0]    pend_n;
  logic [1:0]    want;
  logic          pick_set;
  logic          err_n;
  logic [LW-1:0] lock_cnt;
  logic [LW-1:0] lock_n;

  assign req_raw = {clr_req, set_req};

  // Two-flop synchroniser that brings both raw requests into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= req_raw;
      sync_b <= sync_a;
    end
  end

  // Per-channel debouncer: the stable level follows the synced input only after
  // it has disagreed for DB_CYCLES consecutive cycles.
  for (genvar ch = 0; ch < 2; ch++) begin : g_debounce
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        db_cnt[ch] <= '0;
        stable[ch] <= 1'b0;
      end else if (sync_b[ch] == stable[ch]) begin
        db_cnt[ch] <= '0;
      end else if (db_cnt[ch] == DB_LAST) begin
        db_cnt[ch] <= '0;
        stable[ch] <= sync_b[ch];
      end else begin
        db_cnt[ch] <= db_cnt[ch] + CW'(1);
      end
    end
  end

  // Delayed copy of the stable levels, used to find their rising edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  assign events = stable & ~stable_d;
  assign want   = events | pend;
  assign busy   = (state != IDLE);

  // Next-state logic: select and filter commands in IDLE, park events otherwise.
  always_comb begin
    state_n  = state;
    s_n      = 1'b0;
    r_n      = 1'b0;
    pend_n   = pend | events;
    err_n    = err_both;
    lock_n   = lock_cnt;
    pick_set = 1'b0;
    case (state)
      IDLE: begin
        pend_n = '0;
        if (want[0] && want[1]) begin
          err_n = 1'b1;
        end
        pick_set = want[0] && (!want[1] || SET_WINS);
        if (pick_set) begin
          if (!q_fb) begin
            s_n     = 1'b1;
            state_n = PULSE;
          end
        end else if (want[1]) begin
          if (q_fb) begin
            r_n     = 1'b1;
            state_n = PULSE;
          end
        end
      end
      PULSE: begin
        lock_n  = '0;
        state_n = (LOCKOUT == 0) ? IDLE : LOCK;
      end
      LOCK: begin
        if (lock_cnt == LOCK_LAST) begin
          state_n = IDLE;
        end else begin
          lock_n = lock_cnt + LW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, output pulse, pending, error and lockout registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      s        <= 1'b0;
      r        <= 1'b0;
      pend     <= '0;
      err_both <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      s        <= s_n;
      r        <= r_n;
      pend     <= pend_n;
      err_both <= err_n;
      lock_cnt <= lock_n;
    end
  end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb_sr_drive_ctrl: directed bench for sr_drive_ctrl.
// Two instances share the same stimulus: one where clear wins a conflict and one
// where set wins. A cycle-count based model predicts every output on every cycle.
// A few literal expectations pin the documented timings.
module tb_sr_drive_ctrl;

  localparam int DB_CYCLES = 4;
  localparam int LOCKOUT   = 2;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic q_fb    = 1'b0;

  logic [1:0] dut_s;
  logic [1:0] dut_r;
  logic [1:0] dut_busy;
  logic [1:0] dut_err;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  int s0_cnt   = 0;
  int r0_cnt   = 0;
  int s1_cnt   = 0;
  int r1_cnt   = 0;
  int busy0_cnt = 0;

  // Model state: channel 0 is set, channel 1 is clear; instance i uses PRIO=i.
  int m_edge = 0;
  bit p1 [2];
  bit p2 [2];
  bit stable_m [2];
  bit rose_m [2];
  int agree [2];
  bit pend_m [2][2];
  int last_pulse [2] = '{-1000, -1000};
  bit exp_s [2];
  bit exp_r [2];
  bit exp_err [2];
  bit want_set;
  bit want_clr;
  bit choose_set;
  bit synced;
  bit raw_bit;

  sr_drive_ctrl #(.DB_CYCLES(DB_CYCLES), .LOCKOUT(LOCKOUT), .PRIO(0)) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .set_req  (set_req),
    .clr_req  (clr_req),
    .q_fb     (q_fb),
    .s        (dut_s[0]),
    .r        (dut_r[0]),
    .busy     (dut_busy[0]),
    .err_both (dut_err[0])
  );

  sr_drive_ctrl #(.DB_CYCLES(DB_CYCLES), .LOCKOUT(LOCKOUT), .PRIO(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .set_req  (set_req),
    .clr_req  (clr_req),
    .q_fb     (q_fb),
    .s        (dut_s[1]),
    .r        (dut_r[1]),
    .busy     (dut_busy[1]),
    .err_both (dut_err[1])
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Edge counter used to place stimulus and literal checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic go(input int n);
    while (cyc < n) @(negedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic set_v, input logic clr_v, input logic q_v);
    set_req = set_v;
    clr_req = clr_v;
    q_fb    = q_v;
  endtask

  // Behavioural model: a pulse may follow an event only once LOCKOUT+1 quiet
  // cycles have passed since the previous pulse. A level is accepted once the
  // input two edges back has disagreed with it for DB_CYCLES edges in a row.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        p1[ch]       = 1'b0;
        p2[ch]       = 1'b0;
        stable_m[ch] = 1'b0;
        rose_m[ch]   = 1'b0;
        agree[ch]    = m_edge;
      end
      for (int i = 0; i < 2; i++) begin
        pend_m[i][0]  = 1'b0;
        pend_m[i][1]  = 1'b0;
        last_pulse[i] = m_edge - 1000;
        exp_s[i]      = 1'b0;
        exp_r[i]      = 1'b0;
        exp_err[i]    = 1'b0;
      end
    end else begin
      m_edge++;
      for (int i = 0; i < 2; i++) begin
        exp_s[i] = 1'b0;
        exp_r[i] = 1'b0;
        if (m_edge - 1 > last_pulse[i] + LOCKOUT) begin
          want_set = rose_m[0] | pend_m[i][0];
          want_clr = rose_m[1] | pend_m[i][1];
          pend_m[i][0] = 1'b0;
          pend_m[i][1] = 1'b0;
          if (want_set && want_clr) exp_err[i] = 1'b1;
          if (want_set || want_clr) begin
            choose_set = want_set && (!want_clr || i == 1);
            if (choose_set && !q_fb) begin
              exp_s[i]      = 1'b1;
              last_pulse[i] = m_edge;
            end else if (!choose_set && q_fb) begin
              exp_r[i]      = 1'b1;
              last_pulse[i] = m_edge;
            end
          end
        end else begin
          pend_m[i][0] = pend_m[i][0] | rose_m[0];
          pend_m[i][1] = pend_m[i][1] | rose_m[1];
        end
      end
      for (int ch = 0; ch < 2; ch++) begin
        raw_bit    = (ch == 0) ? set_req : clr_req;
        synced     = p2[ch];
        p2[ch]     = p1[ch];
        p1[ch]     = raw_bit;
        rose_m[ch] = 1'b0;
        if (synced == stable_m[ch]) begin
          agree[ch] = m_edge;
        end else if (m_edge - agree[ch] >= DB_CYCLES) begin
          stable_m[ch] = synced;
          agree[ch]    = m_edge;
          rose_m[ch]   = synced;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("s%0d", i), 32'(dut_s[i]), 32'(exp_s[i]));
      check_output($sformatf("r%0d", i), 32'(dut_r[i]), 32'(exp_r[i]));
      check_output($sformatf("busy%0d", i), 32'(dut_busy[i]),
                   32'((m_edge - last_pulse[i]) <= LOCKOUT));
      check_output($sformatf("err%0d", i), 32'(dut_err[i]), 32'(exp_err[i]));
      check_output($sformatf("s_and_r%0d", i), 32'(dut_s[i] & dut_r[i]), 32'(0));
    end
  end

  // Pulse and busy tallies for the count-based literal checks.
  always @(negedge clk) begin
    if (dut_s[0] === 1'b1) s0_cnt++;
    if (dut_r[0] === 1'b1) r0_cnt++;
    if (dut_s[1] === 1'b1) s1_cnt++;
    if (dut_r[1] === 1'b1) r1_cnt++;
    if (dut_busy[0] === 1'b1) busy0_cnt++;
  end

  initial begin
    int base_s0;
    int base_r0;
    int base_s1;
    int base_r1;
    int base_busy;

    $display("[TB] start");
    apply_stimulus(1'b0, 1'b0, 1'b0);

    go(1);
    check_output("reset_s", 32'(dut_s[0]), 32'(0));
    check_output("reset_r", 32'(dut_r[0]), 32'(0));
    check_output("reset_busy", 32'(dut_busy[0]), 32'(0));
    check_output("reset_err", 32'(dut_err[0]), 32'(0));

    go(3);
    rst = 1'b1;
    go(5);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    go(11);
    check_output("lat_s_before", 32'(dut_s[0]), 32'(0));
    go(12);
    check_output("lat_s_pulse", 32'(dut_s[0]), 32'(1));
    check_output("lat_r_low", 32'(dut_r[0]), 32'(0));
    check_output("lat_busy12", 32'(dut_busy[0]), 32'(1));
    go(13);
    check_output("lat_s_after", 32'(dut_s[0]), 32'(0));
    go(14);
    check_output("lat_busy14", 32'(dut_busy[0]), 32'(1));
    go(15);
    check_output("lat_busy15", 32'(dut_busy[0]), 32'(0));
    go(16);
    apply_stimulus(1'b0, 1'b0, 1'b1);

    go(30);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    base_s0 = s0_cnt;
    go(31);
    set_req = 1'b1;
    go(34);
    set_req = 1'b0;
    go(46);
    check_output("glitch3_no_s", 32'(s0_cnt - base_s0), 32'(0));
    go(47);
    set_req = 1'b1;
    go(51);
    set_req = 1'b0;
    go(66);
    check_output("glitch4_one_s", 32'(s0_cnt - base_s0), 32'(1));
    q_fb = 1'b1;

    base_r0 = r0_cnt;
    base_s1 = s1_cnt;
    base_r1 = r1_cnt;
    go(67);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    go(76);
    check_output("both_prio0_r", 32'(r0_cnt - base_r0), 32'(1));
    check_output("both_prio1_none", 32'((s1_cnt - base_s1) + (r1_cnt - base_r1)), 32'(0));
    check_output("both_err0", 32'(dut_err[0]), 32'(1));
    check_output("both_err1", 32'(dut_err[1]), 32'(1));
    go(77);
    apply_stimulus(1'b0, 1'b0, 1'b0);

    base_s0 = s0_cnt;
    base_r0 = r0_cnt;
    base_s1 = s1_cnt;
    go(92);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    go(101);
    check_output("both_prio1_s", 32'(s1_cnt - base_s1), 32'(1));
    check_output("both_prio0_none", 32'((s0_cnt - base_s0) + (r0_cnt - base_r0)), 32'(0));
    check_output("err0_sticky", 32'(dut_err[0]), 32'(1));
    go(102);
    apply_stimulus(1'b0, 1'b0, 1'b0);

    go(115);
    set_req = 1'b1;
    go(117);
    clr_req = 1'b1;
    go(122);
    check_output("defer_s", 32'(dut_s[0]), 32'(1));
    go(123);
    q_fb = 1'b1;
    check_output("defer_r123", 32'(dut_r[0]), 32'(0));
    go(124);
    check_output("defer_r124", 32'(dut_r[0]), 32'(0));
    go(125);
    check_output("defer_r125", 32'(dut_r[0]), 32'(0));
    go(126);
    check_output("defer_r126", 32'(dut_r[0]), 32'(1));
    check_output("defer_s126", 32'(dut_s[0]), 32'(0));
    go(127);
    apply_stimulus(1'b0, 1'b0, 1'b0);

    go(140);
    base_r0   = r0_cnt;
    base_busy = busy0_cnt;
    apply_stimulus(1'b0, 1'b1, 1'b0);
    go(155);
    check_output("satisfied_no_r", 32'(r0_cnt - base_r0), 32'(0));
    check_output("satisfied_no_busy", 32'(busy0_cnt - base_busy), 32'(0));
    clr_req = 1'b0;

    go(165);
    set_req = 1'b1;
    go(172);
    check_output("mid_pulse_s", 32'(dut_s[0]), 32'(1));
    rst = 1'b0;
    #1;
    check_output("async_s_drop", 32'(dut_s[0]), 32'(0));
    check_output("async_busy_drop", 32'(dut_busy[0]), 32'(0));
    check_output("async_err_clear", 32'(dut_err[0]), 32'(0));
    go(174);
    rst = 1'b1;
    base_s0 = s0_cnt;
    go(180);
    check_output("rerun_s180", 32'(dut_s[0]), 32'(0));
    go(181);
    check_output("rerun_s181", 32'(dut_s[0]), 32'(1));
    go(190);
    check_output("rerun_one_s", 32'(s0_cnt - base_s0), 32'(1));
    set_req = 1'b0;
    go(195);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_drive_ctrl.md
Name: sr_drive_ctrl

Overview:
- Command front-end that sits directly upstream of the SR flip-flop and drives its s/r inputs.
- Takes raw set/clear requests (buttons or remote logic), synchronises and debounces them, and resolves conflicts.
- Emits clean one-cycle s or r pulses with a lockout interval between them.
- Guarantees the illegal s=r=1 combination never reaches the flip-flop, and suppresses commands already satisfied by q.

Parameters:
DB_CYCLES, 4, consecutive stable cycles required before a debounced level changes (>=1)
LOCKOUT, 2, idle cycles forced after every pulse (>=0)
PRIO, 0, simultaneous-request winner: 0 = clear (r) wins, 1 = set (s) wins

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
set_req  input  1  raw set request, asynchronous to clk
clr_req  input  1  raw clear request, asynchronous to clk
q_fb  input  1  current q of downstream SR flip-flop
s  output  1  set pulse to flip-flop, registered
r  output  1  reset pulse to flip-flop, registered
busy  output  1  high while state is PULSE or LOCK
err_both  output  1  sticky: both debounced requests rose in the same cycle

Behaviour:
- Reset (rst=0), asynchronous:
  - s=0, r=0, busy=0, err_both=0.
  - Synchronisers, debounce counters, stable levels, pending flags and lockout counter all cleared; state=IDLE.
  - Applies immediately, independent of clk, including mid-pulse.
- Synchroniser: 2 flops per request input.
- Debounce, per channel:
  - Counter width $clog2(DB_CYCLES+1).
  - Increments each cycle the synced input differs from the stable level; cleared on any cycle they match.
  - When count reaches DB_CYCLES, stable flips and the counter clears.
- Event: rising edge of a stable level. Falling edges are ignored.
- Latency: raw request high and held from edge E gives s (or r) high for exactly the one cycle after edge E+DB_CYCLES+3.
- FSM states are IDLE, PULSE and LOCK.
- IDLE:
  - On an event (or a pending flag), select the command.
  - If both are present, set err_both and pick according to PRIO; the loser is dropped.
  - If the selected command is already satisfied (set with q_fb=1, or clear with q_fb=0), drop it, emit no pulse and stay in IDLE.
  - Otherwise go to PULSE with the matching output registered high.
- PULSE: lasts exactly one cycle with s xor r high. Go to LOCK, or to IDLE when LOCKOUT=0.
- LOCK:
  - Counts LOCKOUT cycles with s=r=0, then goes to IDLE.
  - Pending flags are evaluated on the first IDLE cycle, so the next pulse is no earlier than LOCKOUT+1 cycles after the previous one.
- Events arriving during PULSE or LOCK set a per-channel pending flag.
  - Repeats of the same channel merge into one flag.
  - Flags are cleared when consumed or dropped in IDLE.
- Invariant: s & r == 0 in every cycle, including the cycle of reset release.
- err_both is cleared only by rst.
- Inputs held high through reset release:
  - Stable levels restart at 0, so a held request produces a fresh event after the normal latency.
  - The event is still subject to q_fb suppression.

Test Plan:
- rst=0 at t=0, release at edge 3, set_req held 1 from edge 5, q_fb=0, DB_CYCLES=4 -> s=1 only in the cycle after edge 12, r=0 throughout; busy high in the cycles after edges 12 through 14.
- set_req glitch of 3 cycles (< DB_CYCLES) -> no s pulse, counter returns to 0; a 4-cycle pulse -> exactly one s pulse.
- set_req and clr_req rise on the same edge, q_fb=1, PRIO=0 -> single r pulse, err_both=1 and sticky; repeat with PRIO=1 and q_fb=0 -> single s pulse.
- Set event, then a clr event 1 cycle after the s pulse (during LOCK, LOCKOUT=2) -> r pulse deferred until 3 cycles after s; s and r never overlap.
- clr_req asserted while q_fb=0 -> no r pulse, busy stays 0.
- rst asserted in the middle of the PULSE cycle -> s drops to 0 asynchronously and pending is cleared; after release, a request still held high gives one new pulse after DB_CYCLES+3 cycles.
